// File: rtl/apb_mem_completer_if.sv
`default_nettype none
// ============================================================================
//  Module  : apb_mem_completer_if
//  Brief   : APB bus bundle between a requester and the memory completer.
//  Revision: 1.0 - initial release
// ============================================================================
interface apb_mem_completer_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 21
);
   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface
`default_nettype wire

// File: rtl/apb_mem_completer.sv
`default_nettype none
// ============================================================================
//  Module  : apb_mem_completer
//  Brief   : APB completer backed by a DEPTH-word register memory with
//            programmable wait states and out-of-range PSLVERR.
//  Revision: 1.0 - initial release
// ============================================================================
module apb_mem_completer #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 21,
   parameter int DEPTH       = 200,
   parameter int WAIT_STATES = 1
) (
   input  wire logic          clk,
   input  wire logic          PRESETn,
   apb_mem_completer_if.slave bus
);

   localparam int                c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   c_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [3:0]        c_WAIT  = 4'(WAIT_STATES);

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [3:0]           r_cnt;
   logic [3:0]           w_cnt_nxt;
   logic                 w_latch;
   logic [c_IDX_W-1:0]   r_idx;
   logic                 r_write;
   logic                 r_err;
   logic [DATA_W-1:0]    r_wdata;
   logic [DATA_W-1:0]    r_mem [DEPTH];
   logic                 w_ready;
   logic                 w_mem_we;
   logic                 w_addr_err;

   assign w_addr_err = ({1'b0, bus.PADDR} >= c_DEPTH);

   always_ff @(posedge clk or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_latch     = 1'b0;
      case (r_state)
         S_IDLE: begin
            // A select with PENABLE already high has no setup phase and is dropped.
            if (bus.PSEL && !bus.PENABLE) begin
               w_state_nxt = S_ACCESS;
               w_cnt_nxt   = c_WAIT;
               w_latch     = 1'b1;
            end
         end
         S_ACCESS: begin
            if (r_cnt == 4'd0) begin
               w_state_nxt = S_IDLE;
            end else if (!bus.PSEL) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = 4'd0;
            end else begin
               w_cnt_nxt   = r_cnt - 4'd1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge PRESETn) begin
      if (!PRESETn) begin
         r_idx   <= '0;
         r_write <= 1'b0;
         r_err   <= 1'b0;
         r_wdata <= '0;
      end else if (w_latch) begin
         r_idx   <= bus.PADDR[c_IDX_W-1:0];
         r_write <= bus.PWRITE;
         r_err   <= w_addr_err;
         r_wdata <= bus.PWDATA;
      end
   end

   // Completion is a pure function of registered state; no bus-input paths to outputs.
   assign w_ready  = (r_state == S_ACCESS) && (r_cnt == 4'd0);
   assign w_mem_we = w_ready && r_write && !r_err && bus.PSEL && bus.PENABLE;

   always_ff @(posedge clk or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_mem_we) begin
         r_mem[r_idx] <= r_wdata;
      end
   end

   assign bus.PREADY  = w_ready;
   assign bus.PSLVERR = w_ready && r_err;
   assign bus.PRDATA  = (w_ready && !r_write && !r_err) ? r_mem[r_idx] : '0;

endmodule
`default_nettype wire

// File: tb/tb_apb_mem_completer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_apb_mem_completer
//  Brief   : Directed self-checking bench; three completers with 1, 3 and 2
//            wait states share one clock, reset and requester.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_apb_mem_completer;

   localparam int c_ADDR_W = 8;
   localparam int c_DATA_W = 21;
   localparam int c_DEPTH  = 200;

   logic clk;
   logic PRESETn;

   logic                psel;
   logic                penable;
   logic                pwrite;
   logic [c_ADDR_W-1:0] paddr;
   logic [c_DATA_W-1:0] pwdata;
   int                  sel;

   logic [c_DATA_W-1:0] obs_rdata;
   logic                obs_ready;
   logic                obs_slverr;

   int checks;
   int failures;

   int                  c_WS [3] = '{1, 3, 2};
   logic [c_DATA_W-1:0] model0 [c_DEPTH];

   apb_mem_completer_if #(.ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W)) bus0 ();
   apb_mem_completer_if #(.ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W)) bus1 ();
   apb_mem_completer_if #(.ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W)) bus2 ();

   assign bus0.PSEL    = psel && (sel == 0);
   assign bus1.PSEL    = psel && (sel == 1);
   assign bus2.PSEL    = psel && (sel == 2);
   assign bus0.PENABLE = penable;
   assign bus1.PENABLE = penable;
   assign bus2.PENABLE = penable;
   assign bus0.PWRITE  = pwrite;
   assign bus1.PWRITE  = pwrite;
   assign bus2.PWRITE  = pwrite;
   assign bus0.PADDR   = paddr;
   assign bus1.PADDR   = paddr;
   assign bus2.PADDR   = paddr;
   assign bus0.PWDATA  = pwdata;
   assign bus1.PWDATA  = pwdata;
   assign bus2.PWDATA  = pwdata;

   apb_mem_completer #(.ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W), .DEPTH(c_DEPTH), .WAIT_STATES(1))
      u_dut0 (.clk(clk), .PRESETn(PRESETn), .bus(bus0.slave));
   apb_mem_completer #(.ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W), .DEPTH(c_DEPTH), .WAIT_STATES(3))
      u_dut1 (.clk(clk), .PRESETn(PRESETn), .bus(bus1.slave));
   apb_mem_completer #(.ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W), .DEPTH(c_DEPTH), .WAIT_STATES(2))
      u_dut2 (.clk(clk), .PRESETn(PRESETn), .bus(bus2.slave));

   always_comb begin
      obs_rdata  = bus0.PRDATA;
      obs_ready  = bus0.PREADY;
      obs_slverr = bus0.PSLVERR;
      case (sel)
         1: begin
            obs_rdata  = bus1.PRDATA;
            obs_ready  = bus1.PREADY;
            obs_slverr = bus1.PSLVERR;
         end
         2: begin
            obs_rdata  = bus2.PRDATA;
            obs_ready  = bus2.PREADY;
            obs_slverr = bus2.PSLVERR;
         end
         default: ;
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // One full transfer; returns just after the completion edge so the next call is back-to-back.
   task automatic xfer(input int d, input logic wr, input logic [c_ADDR_W-1:0] a,
                       input logic [c_DATA_W-1:0] wd,
                       output logic [c_DATA_W-1:0] rd, output logic err);
      int n;
      @(negedge clk);
      sel = d; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
      @(negedge clk);
      penable = 1'b1;
      n = 1;
      while (!obs_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("latency", n, c_WS[d] + 1);
      rd  = obs_rdata;
      err = obs_slverr;
      @(posedge clk);
   endtask

   task automatic bus_idle();
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [c_DATA_W-1:0] rd;
      logic                er;
      int                  n;
      logic [c_ADDR_W-1:0] ra;
      logic [c_DATA_W-1:0] rdat;

      checks = 0; failures = 0;
      sel = 0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      for (int i = 0; i < c_DEPTH; i++) model0[i] = '0;
      PRESETn = 1'b0;
      repeat (3) @(negedge clk);
      PRESETn = 1'b1;
      @(negedge clk);
      check("rst_pready", obs_ready, 0);
      check("rst_pslverr", obs_slverr, 0);
      check("rst_prdata", obs_rdata, 0);

      // Access phase without setup must be ignored
      psel = 1'b1; penable = 1'b1; paddr = 8'h00; pwrite = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("nosetup_pready", obs_ready, 0);
      end
      bus_idle();

      // 1: read of a cleared word
      xfer(0, 1'b0, 8'h00, '0, rd, er);
      check("t1_rdata", rd, 0);
      check("t1_err", er, 0);

      // 2: write then back-to-back read
      xfer(0, 1'b1, 8'h12, 21'd10, rd, er);
      model0[8'h12] = 21'd10;
      check("t2_werr", er, 0);
      xfer(0, 1'b0, 8'h12, '0, rd, er);
      check("t2_rdata", rd, 21'd10);
      check("t2_err", er, 0);
      bus_idle();

      // 3: out-of-range address handling
      xfer(0, 1'b1, 8'hC7, 21'h0C0FFE, rd, er);
      model0[8'hC7] = 21'h0C0FFE;
      check("t3_w_c7_err", er, 0);
      xfer(0, 1'b1, 8'hC8, 21'h1FFFFF, rd, er);
      check("t3_w_c8_err", er, 1);
      xfer(0, 1'b0, 8'hC8, '0, rd, er);
      check("t3_r_c8_rdata", rd, 0);
      check("t3_r_c8_err", er, 1);
      bus_idle();
      check("t3_after_pslverr", obs_slverr, 0);
      check("t3_after_pready", obs_ready, 0);
      xfer(0, 1'b0, 8'hC7, '0, rd, er);
      check("t3_r_c7_rdata", rd, 21'h0C0FFE);
      check("t3_r_c7_err", er, 0);
      xfer(0, 1'b0, 8'hFF, '0, rd, er);
      check("t3_r_ff_err", er, 1);
      bus_idle();

      // 4: three wait states
      xfer(1, 1'b1, 8'h19, 21'd27, rd, er);
      check("t4_werr", er, 0);
      xfer(1, 1'b0, 8'h19, '0, rd, er);
      check("t4_rdata", rd, 21'd27);
      bus_idle();

      // 6: random write/read pairs against the scoreboard
      for (int k = 0; k < 15; k++) begin
         ra   = c_ADDR_W'($urandom_range(c_DEPTH - 1, 0));
         rdat = c_DATA_W'($urandom);
         xfer(0, 1'b1, ra, rdat, rd, er);
         model0[ra] = rdat;
         xfer(0, 1'b0, ra, '0, rd, er);
         check("t6_rdata", rd, model0[ra]);
         check("t6_err", er, 0);
      end
      xfer(0, 1'b0, 8'hC7, '0, rd, er);
      check("t6_c7_rdata", rd, model0[8'hC7]);
      bus_idle();

      // 5: abort by dropping PSEL (two wait states)
      xfer(2, 1'b1, 8'h05, 21'h0ABCD, rd, er);
      bus_idle();
      @(negedge clk);
      sel = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h05; pwdata = 21'h15555;
      @(negedge clk);
      penable = 1'b1;
      check("t5_wait1", obs_ready, 0);
      @(negedge clk);
      check("t5_wait2", obs_ready, 0);
      psel = 1'b0; penable = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("t5_abort_pready", obs_ready, 0);
      end
      xfer(2, 1'b0, 8'h05, '0, rd, er);
      check("t5_prior", rd, 21'h0ABCD);
      bus_idle();

      // 5: reset while completion is being presented
      @(negedge clk);
      sel = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h05;
      @(negedge clk);
      penable = 1'b1;
      n = 1;
      while (!obs_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t5_rst_pre_rdata", obs_rdata, 21'h0ABCD);
      PRESETn = 1'b0;
      #1;
      check("t5_rst_pready", obs_ready, 0);
      check("t5_rst_prdata", obs_rdata, 0);
      check("t5_rst_pslverr", obs_slverr, 0);
      psel = 1'b0; penable = 1'b0;
      repeat (2) @(negedge clk);
      PRESETn = 1'b1;
      xfer(2, 1'b0, 8'h05, '0, rd, er);
      check("t5_cleared_05", rd, 0);
      xfer(0, 1'b0, 8'h12, '0, rd, er);
      check("t5_cleared_12", rd, 0);
      bus_idle();
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
